// File: rtl/ysyx_24120013_fetch_pkg.sv
// Shared types and constants for the ysyx_24120013 fetch front end.
// The HALT state exists only when YSYX_24120013_FETCH_MISALIGN_EN is defined.
package ysyx_24120013_fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

`ifdef YSYX_24120013_FETCH_MISALIGN_EN
  typedef enum logic [1:0] {REQ, WAIT, DROP, HALT} fetch_state_e;
`else
  typedef enum logic [1:0] {REQ, WAIT, DROP} fetch_state_e;
`endif

endpackage

// File: rtl/ysyx_24120013_inst_fifo.sv
// Registered instruction FIFO between memory responses and decode.
// Flush clears the queue but still accepts a same-cycle push as the new head.
module ysyx_24120013_inst_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (flush || !full || do_pop);

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    if (do_push) begin
      mem_d[wr_ptr_d] = push_data;
      wr_ptr_d        = wr_ptr_d + 1'b1;
      count_d         = count_d + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_d - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ysyx_24120013_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues one request at a time, buffers words.
// YSYX_24120013_FETCH_MISALIGN_EN turns misaligned redirects into a fault entry plus HALT.
module ysyx_24120013_fetch_unit
  import ysyx_24120013_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_fault
);

  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  fault;
  } entry_t;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, issued_pc_q, issued_pc_d;
  logic                  req_fire, outstanding;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  entry_t                push_entry, head_entry;

  assign mem_req_valid = !rst && (state_q == REQ) && !fifo_full;
  assign mem_req_addr  = pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign inst_valid    = !fifo_empty;
  assign fifo_pop      = inst_valid && inst_ready;
  assign inst          = head_entry.inst;
  assign inst_pc       = head_entry.pc;
  // Only the misalign build ever pushes a set fault bit.
  assign inst_fault    = head_entry.fault;

`ifdef YSYX_24120013_FETCH_MISALIGN_EN
  logic stale_q, stale_d;
  logic misaligned;
  assign misaligned = (redirect_pc[1:0] != 2'b00);
`endif

  // A request is still owed a response after this cycle.
  always_comb begin
    outstanding = 1'b0;
    case (state_q)
      REQ:        outstanding = req_fire;
      WAIT, DROP: outstanding = !mem_resp_valid;
`ifdef YSYX_24120013_FETCH_MISALIGN_EN
      HALT:       outstanding = stale_q && !mem_resp_valid;
`endif
      default:    outstanding = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issued_pc_d = issued_pc_q;
    fifo_push   = 1'b0;
    push_entry  = '{inst: mem_resp_data, pc: issued_pc_q, fault: 1'b0};
    if (redirect_en) begin
      pc_d    = redirect_pc & ~ADDR_WIDTH'(3);
      state_d = outstanding ? DROP : REQ;
`ifdef YSYX_24120013_FETCH_MISALIGN_EN
      if (misaligned) begin
        pc_d       = redirect_pc;
        state_d    = HALT;
        fifo_push  = 1'b1;
        push_entry = '{inst: DATA_WIDTH'(NOP_INST), pc: redirect_pc, fault: 1'b1};
      end
`endif
    end else begin
      case (state_q)
        REQ: if (req_fire) begin
          issued_pc_d = pc_q;
          pc_d        = pc_q + ADDR_WIDTH'(4);
          state_d     = WAIT;
        end
        WAIT: if (mem_resp_valid) begin
          fifo_push = 1'b1;
          state_d   = REQ;
        end
        DROP: if (mem_resp_valid) state_d = REQ;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      issued_pc_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issued_pc_q <= issued_pc_d;
    end
  end

`ifdef YSYX_24120013_FETCH_MISALIGN_EN
  // Remembers a response still in flight when HALT was entered.
  always_comb begin
    stale_d = stale_q;
    if (redirect_en) stale_d = misaligned && outstanding;
    else if (state_q == HALT && mem_resp_valid) stale_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) stale_q <= 1'b0;
    else     stale_q <= stale_d;
  end
`endif

  ysyx_24120013_inst_fifo #(
    .DEPTH(BUF_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_inst_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_en),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .head_data(head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ysyx_24120013_fetch_unit.sv
// Self-checking bench for ysyx_24120013_fetch_unit: vector table, directed corner cases,
// and randomized traffic against a stream-level model of the fetch sequence.
module tb_ysyx_24120013_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk, rst, redirect_en, mem_req_ready, mem_resp_valid, inst_ready;
  logic [31:0] redirect_pc, mem_resp_data;
  logic        mem_req_valid, inst_valid, inst_fault;
  logic [31:0] mem_req_addr, inst, inst_pc;

  ysyx_24120013_fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory model: one pending response, delivered lat cycles after the handshake.
  bit          pend_valid;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          lat = 1;

  // Stream model: next address to be requested and next PC decode should see.
  logic [31:0] exp_req_pc, exp_inst_pc;
  bit          halted;
  int          deliv, hs_count;
  logic [31:0] hs_addrs[$];

  logic        snap_req_valid, snap_inst_valid, snap_fault;
  logic [31:0] snap_req_addr, snap_inst, snap_inst_pc;

  typedef struct {
    logic rst; logic mrdy; logic rvalid; logic [31:0] rdata; logic irdy;
    logic e_req; logic [31:0] e_addr; logic e_ival; logic [31:0] e_inst; logic [31:0] e_pc;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mkVec(input logic r, input logic mrdy, input logic rv,
                                 input logic [31:0] rd, input logic irdy, input logic er,
                                 input logic [31:0] ea, input logic ei, input logic [31:0] einst,
                                 input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.mrdy = mrdy; v.rvalid = rv; v.rdata = rd; v.irdy = irdy;
    v.e_req = er; v.e_addr = ea; v.e_ival = ei; v.e_inst = einst; v.e_pc = epc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic modelRedirect(input logic [31:0] rpc);
    logic [31:0] t;
    t = rpc;
`ifdef YSYX_24120013_FETCH_MISALIGN_EN
    if (t[1:0] != 2'b00) halted = 1'b1;
    else begin exp_req_pc = t; exp_inst_pc = t; end
`else
    exp_req_pc  = t & 32'hFFFF_FFFC;
    exp_inst_pc = t & 32'hFFFF_FFFC;
`endif
  endtask

  // One clock cycle with the automatic memory and the scoreboard in the loop.
  task automatic applyStimulus(input logic r, input logic redir, input logic [31:0] rpc,
                               input logic irdy, input logic mrdy);
    @(negedge clk);
    rst = r; redirect_en = redir; redirect_pc = rpc; inst_ready = irdy; mem_req_ready = mrdy;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    if (r) pend_valid = 1'b0;
    else if (pend_valid) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = memWord(pend_addr);
        pend_valid     = 1'b0;
      end
    end
    #1;
    snap_req_valid = mem_req_valid; snap_req_addr = mem_req_addr;
    snap_inst_valid = inst_valid; snap_inst = inst; snap_inst_pc = inst_pc; snap_fault = inst_fault;
    if (r) begin
      exp_req_pc = RESET_PC; exp_inst_pc = RESET_PC; halted = 1'b0;
    end else begin
      if (mem_req_valid && mrdy) begin
        if (!halted) checkOutput("req_addr", mem_req_addr, exp_req_pc);
        hs_count++;
        hs_addrs.push_back(mem_req_addr);
        pend_valid = 1'b1; pend_addr = mem_req_addr; pend_cnt = lat;
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (inst_valid && irdy && !redir && !halted) begin
        checkOutput("inst_pc", inst_pc, exp_inst_pc);
        checkOutput("inst_word", inst, memWord(exp_inst_pc));
        checkOutput("inst_fault", 32'(inst_fault), 32'd0);
        exp_inst_pc = exp_inst_pc + 32'd4;
        deliv++;
      end
      if (redir) modelRedirect(rpc);
    end
    @(posedge clk);
  endtask

  task automatic applyVector(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; redirect_en = 1'b0; redirect_pc = '0; inst_ready = v.irdy;
    mem_req_ready = v.mrdy; mem_resp_valid = v.rvalid; mem_resp_data = v.rdata;
    #1;
    checkOutput($sformatf("vec%0d_req_valid", idx), 32'(mem_req_valid), 32'(v.e_req));
    if (v.e_req) checkOutput($sformatf("vec%0d_req_addr", idx), mem_req_addr, v.e_addr);
    checkOutput($sformatf("vec%0d_inst_valid", idx), 32'(inst_valid), 32'(v.e_ival));
    if (v.e_ival || v.rst) begin
      checkOutput($sformatf("vec%0d_inst", idx), inst, v.e_inst);
      checkOutput($sformatf("vec%0d_inst_pc", idx), inst_pc, v.e_pc);
    end
    checkOutput($sformatf("vec%0d_fault", idx), 32'(inst_fault), 32'd0);
    @(posedge clk);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    deliv = 0; hs_count = 0; hs_addrs.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] tgt;
    int          mark;
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; inst_ready = 1'b0;

    // 1-cycle memory streaming straight after reset
    vecs[0] = mkVec(1, 1, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        32'h0);
    vecs[1] = mkVec(0, 1, 0, 32'h0,        1, 1, 32'h8000_0000, 0, 32'h0,        32'h0);
    vecs[2] = mkVec(0, 1, 1, 32'h0050_0093, 1, 0, 32'h0,        0, 32'h0,        32'h0);
    vecs[3] = mkVec(0, 1, 0, 32'h0,        1, 1, 32'h8000_0004, 1, 32'h0050_0093, 32'h8000_0000);
    vecs[4] = mkVec(0, 1, 1, 32'h00a0_0113, 1, 0, 32'h0,        0, 32'h0,        32'h0);
    vecs[5] = mkVec(0, 1, 0, 32'h0,        1, 1, 32'h8000_0008, 1, 32'h00a0_0113, 32'h8000_0004);
    vecs[6] = mkVec(0, 1, 1, 32'h0020_81b3, 1, 0, 32'h0,        0, 32'h0,        32'h0);
    vecs[7] = mkVec(0, 0, 0, 32'h0,        1, 1, 32'h8000_000C, 1, 32'h0020_81b3, 32'h8000_0008);
    vecs[8] = mkVec(0, 0, 0, 32'h0,        1, 1, 32'h8000_000C, 0, 32'h0,        32'h0);

    doReset();
    for (int i = 0; i < 9; i++) applyVector(vecs[i], i);

    // Backpressure: FIFO fills with two words, then fetching resumes at +8
    lat = 1;
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, '0, 0, 1);
    checkOutput("full_req_valid", 32'(snap_req_valid), 32'd0);
    checkOutput("full_hs_count", 32'(hs_count), 32'd2);
    checkOutput("full_head_pc", snap_inst_pc, RESET_PC);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, '0, 1, 1);
    checkOutput("resume_addr", (hs_addrs.size() > 2) ? hs_addrs[2] : 32'hDEAD_BEEF, 32'h8000_0008);
    checkOutput("drain_count", 32'(deliv >= 3), 32'd1);

    // Redirect in the same cycle as the response for 0x80000004
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 1, 1);
    applyStimulus(0, 1, 32'h8000_1000, 1, 1);
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("redir_req_valid", 32'(snap_req_valid), 32'd1);
    checkOutput("redir_req_addr", snap_req_addr, 32'h8000_1000);
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("redir_no_stale", 32'(snap_inst_valid), 32'd0);
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("redir_first_pc", snap_inst_pc, 32'h8000_1000);

    // Redirect while waiting on a 3-cycle memory: stale word dropped
    lat = 3;
    doReset();
    applyStimulus(0, 0, '0, 1, 1);
    applyStimulus(0, 1, 32'h8000_2000, 1, 1);
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("drop_no_req", 32'(snap_req_valid), 32'd0);
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("drop_no_req2", 32'(snap_req_valid), 32'd0);
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("drop_req_valid", 32'(snap_req_valid), 32'd1);
    checkOutput("drop_req_addr", snap_req_addr, 32'h8000_2000);
    checkOutput("drop_inst_valid", 32'(snap_inst_valid), 32'd0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, '0, 1, 1);
    checkOutput("drop_deliv", 32'(deliv >= 2), 32'd1);

    // Misaligned redirect
    lat = 1;
    doReset();
    applyStimulus(0, 1, 32'h8000_0002, 0, 0);
    applyStimulus(0, 0, '0, 0, 1);
`ifdef YSYX_24120013_FETCH_MISALIGN_EN
    checkOutput("mis_inst_valid", 32'(snap_inst_valid), 32'd1);
    checkOutput("mis_inst_pc", snap_inst_pc, 32'h8000_0002);
    checkOutput("mis_inst", snap_inst, 32'h0000_0013);
    checkOutput("mis_fault", 32'(snap_fault), 32'd1);
    checkOutput("mis_no_req", 32'(snap_req_valid), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 1, 1);
    checkOutput("mis_halt_req", 32'(snap_req_valid), 32'd0);
    checkOutput("mis_halt_hs", 32'(hs_count), 32'd0);
`else
    checkOutput("mis_req_valid", 32'(snap_req_valid), 32'd1);
    checkOutput("mis_req_addr", snap_req_addr, 32'h8000_0000);
    checkOutput("mis_fault", 32'(snap_fault), 32'd0);
`endif

    // Reset asserted while waiting with a word buffered
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 0, 1);
    checkOutput("rst_pre_valid", 32'(snap_inst_valid), 32'd1);
    applyStimulus(1, 0, '0, 0, 1);
    applyStimulus(1, 0, '0, 0, 1);
    checkOutput("rst_inst_valid", 32'(snap_inst_valid), 32'd0);
    checkOutput("rst_req_valid", 32'(snap_req_valid), 32'd0);
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("rst_first_req", 32'(snap_req_valid), 32'd1);
    checkOutput("rst_first_addr", snap_req_addr, RESET_PC);

    // Randomized traffic against the stream model
    doReset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) lat = $urandom_range(1, 4);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
`ifdef YSYX_24120013_FETCH_MISALIGN_EN
      tgt = tgt & 32'hFFFF_FFFC;
`endif
      applyStimulus(0, $urandom_range(0, 99) < 3, tgt,
                    $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75);
    end
    checkOutput("random_liveness", 32'(deliv >= 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24120013_fetch_unit.md
# ysyx_24120013_fetch_unit

Instruction fetch front end for the ysyx_24120013 core. Owns the fetch PC and issues one-word requests to instruction memory over a valid/ready request channel with a valid-only response. Buffers returned words in a small FIFO and hands them to the decode stage over a valid/ready channel. Accepts a redirect (jump/branch/trap target) from the execute side that flushes all in-flight work.

## Interface
- ADDR_WIDTH, 32, PC and memory address width
- DATA_WIDTH, 32, instruction word width
- RESET_PC, 32'h8000_0000, first fetch address after reset
- BUF_DEPTH, 2, instruction FIFO entries; power of two, ≥ 2

- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- redirect_en  in  1  one-cycle pulse: load new fetch PC and flush
- redirect_pc  in  ADDR_WIDTH  redirect target
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts request this cycle
- mem_req_addr  out  ADDR_WIDTH  fetch address (current fetch PC)
- mem_resp_valid  in  1  response word valid; never back-pressured
- mem_resp_data  in  DATA_WIDTH  instruction word
- inst_valid  out  1  FIFO head valid toward decode
- inst_ready  in  1  decode consumes head this cycle
- inst  out  DATA_WIDTH  instruction at FIFO head
- inst_pc  out  ADDR_WIDTH  PC of that instruction
- inst_fault  out  1  head entry carries a misaligned-fetch fault

## Operation
- FSM states: REQ, WAIT, DROP, HALT.
- REQ: mem_req_valid=1 only if FIFO occupancy < BUF_DEPTH (occupancy alone suffices, since at most one request is outstanding). On handshake: fetch_pc += 4 (modulo 2^ADDR_WIDTH, wraps silently); go to WAIT.
- WAIT: on mem_resp_valid, push {mem_resp_data, issued PC, fault=0} into FIFO; go to REQ. No new request is issued in WAIT.
- DROP: the next mem_resp_valid is discarded; go to REQ.
- HALT: no requests; leave only on redirect.
- Redirect has priority over every same-cycle event:
  - fetch_pc ← redirect_pc and FIFO flushed.
  - A same-cycle push or pop is lost.
  - Next state: DROP if a request is outstanding after this cycle (state WAIT without response this cycle, or REQ with a handshake this cycle); otherwise REQ.
  - An unaccepted pending request is withdrawn; the memory side tolerates withdrawal.
- FIFO pop occurs when inst_valid & inst_ready. Push and pop in the same cycle are both legal when the FIFO is full or empty. Empty: inst_valid=0. Full: no request issued.
- mem_req_addr and the PC stored with each entry are the fetch PC at handshake.

## Timing
- Reset values: mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_fault=0, fetch_pc=RESET_PC, state=REQ, FIFO empty.
- First request: mem_req_valid=1 with mem_req_addr=RESET_PC in the first cycle after rst falls.
- Memory response arrives ≥1 cycle after handshake. inst_valid rises the cycle after the push (registered FIFO).
- Peak throughput with a 1-cycle memory: one instruction per 2 cycles.
- First request after a redirect: the cycle after redirect_en, unless the FSM is in DROP.
- rst mid-transaction: all state returns to reset values; any late response is ignored only if it arrives while rst is high. Memory must be reset together with this block.

## Configuration
- YSYX_24120013_FETCH_MISALIGN_EN defined: a redirect_pc with [1:0]≠0 issues no request. One entry {inst=32'h0000_0013, inst_pc=redirect_pc, inst_fault=1} is pushed, then the FSM enters HALT until the next redirect.
- Not defined: redirect_pc[1:0] is forced to 0. inst_fault is tied 0 and the HALT state is not built. The port exists in both builds.

## Structure
- Package ysyx_24120013_fetch_pkg: FSM state enum, NOP constant 32'h0000_0013, default RESET_PC.
- One sub-module: ysyx_24120013_inst_fifo. Parameterised depth and width (DATA_WIDTH+ADDR_WIDTH+1), with push/pop/flush inputs and full/empty outputs; pointers wrap at BUF_DEPTH.

## Test plan
- Reset then stream, memory with 1-cycle latency, inst_ready=1: requests 0x80000000, 0x80000004, 0x80000008 → inst_pc values in that order, one every 2 cycles, inst_fault=0.
- Hold inst_ready=0: after 2 words, mem_req_valid stays 0 while the FIFO is full. Release → occupancy drains and fetching resumes at 0x80000008.
- Redirect to 0x80001000 in the same cycle a response arrives for 0x80000004 → that word is never presented; the next inst_pc is 0x80001000.
- Redirect while WAIT with a 3-cycle memory → FSM enters DROP; the stale response is discarded; the next request address is the redirect target.
- Macro defined, redirect to 0x80000002 → a single entry with inst_pc=0x80000002, inst=0x00000013, inst_fault=1, and no mem_req_valid afterwards. Macro undefined → request address 0x80000000.
- Assert rst while WAIT with entries buffered → the next cycle shows inst_valid=0 and mem_req_valid=0; after release, the first request is to 0x80000000.
